// File: rtl/timer_delay_arbiter_if.sv
// rtl/timer_delay_arbiter_if.sv - Avalon-MM register port between the delay arbiter and the interval timer
interface timer_delay_arbiter_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata,
    output tmr_irq
  );
endinterface

// File: rtl/timer_delay_arbiter.sv
// rtl/timer_delay_arbiter.sv - round-robin sharing of one interval timer among one-shot delay requesters
module timer_delay_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DLY_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DLY_W-1:0] delay_flat,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  timer_delay_arbiter_if.master    tmr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Timer register map and control words.
  localparam logic [2:0]  ADDR_STATUS   = 3'd0;
  localparam logic [2:0]  ADDR_CONTROL  = 3'd1;
  localparam logic [2:0]  ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0]  ADDR_PERIOD_H = 3'd3;
  localparam logic [15:0] CTRL_ONESHOT  = 16'h0005;  // START | ITO, CONT = 0
  localparam logic [15:0] CTRL_STOP     = 16'h0008;
  localparam logic [15:0] STATUS_CLEAR  = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_WAIT_IRQ,
    S_WR_STOP,
    S_CLR_STAT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             cancel_q, cancel_d;

  logic [DLY_W-1:0] dly_arr [NUM_REQ];
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] ptr_inc;
  logic             win_found;
  int               cand_sum;

  // Next values of the registered outputs, decoded from the next state so
  // every output lines up with the state it belongs to.
  logic [NUM_REQ-1:0] owner_oh_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [NUM_REQ-1:0] done_d;
  logic               busy_d;
  logic               cs_d;
  logic               wn_d;
  logic [2:0]         addr_d;
  logic [15:0]        wdata_d;

  // Split the flat delay bus into one entry per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      dly_arr[i] = delay_flat[i*DLY_W +: DLY_W];
    end
  end

  // Round-robin search starting at ptr; walking downwards lets the first
  // candidate after ptr overwrite any later one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    cand_sum  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_sum = (int'(ptr_q) + k) % NUM_REQ;
      cand     = PTR_W'(cand_sum);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    ptr_inc = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
  end

  // Next-state logic and decode of the registered outputs.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    dly_d    = dly_q;
    cancel_d = cancel_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d  = win_idx;
          ptr_d    = ptr_inc;
          dly_d    = dly_arr[win_idx];
          cancel_d = 1'b0;
          state_d  = (dly_arr[win_idx] == '0) ? S_DONE : S_WR_PL;
        end
      end
      S_WR_PL:    state_d = S_WR_PH;
      S_WR_PH:    state_d = S_WR_CTRL;
      S_WR_CTRL:  state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        // Expiry beats a simultaneous cancel: the delay really elapsed.
        if (tmr.tmr_irq) begin
          state_d = S_CLR_STAT;
        end else if (!req[owner_q]) begin
          state_d  = S_WR_STOP;
          cancel_d = 1'b1;
        end
      end
      S_WR_STOP:  state_d = S_CLR_STAT;
      S_CLR_STAT: state_d = cancel_q ? S_IDLE : S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    owner_oh_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_d;
    grant_d    = (state_d == S_IDLE) ? '0 : owner_oh_d;
    done_d     = (state_d == S_DONE) ? owner_oh_d : '0;
    busy_d     = (state_d != S_IDLE);

    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = ADDR_STATUS;
    wdata_d = 16'h0000;
    case (state_d)
      S_WR_PL: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADDR_PERIOD_L;
        wdata_d = dly_d[15:0];
      end
      S_WR_PH: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADDR_PERIOD_H;
        wdata_d = dly_d[31:16];
      end
      S_WR_CTRL: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADDR_CONTROL;
        wdata_d = CTRL_ONESHOT;
      end
      S_WR_STOP: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADDR_CONTROL;
        wdata_d = CTRL_STOP;
      end
      S_CLR_STAT: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADDR_STATUS;
        wdata_d = STATUS_CLEAR;
      end
      default: begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
      end
    endcase
  end

  // State, transaction context and all outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      ptr_q              <= '0;
      owner_q            <= '0;
      dly_q              <= '0;
      cancel_q           <= 1'b0;
      grant              <= '0;
      done               <= '0;
      busy               <= 1'b0;
      tmr.tmr_chipselect <= 1'b0;
      tmr.tmr_write_n    <= 1'b1;
      tmr.tmr_address    <= 3'd0;
      tmr.tmr_writedata  <= 16'h0000;
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      owner_q            <= owner_d;
      dly_q              <= dly_d;
      cancel_q           <= cancel_d;
      grant              <= grant_d;
      done               <= done_d;
      busy               <= busy_d;
      tmr.tmr_chipselect <= cs_d;
      tmr.tmr_write_n    <= wn_d;
      tmr.tmr_address    <= addr_d;
      tmr.tmr_writedata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_timer_delay_arbiter.sv
// tb/tb_timer_delay_arbiter.sv - directed vector bench for timer_delay_arbiter
module tb_timer_delay_arbiter;
  localparam int N  = 4;
  localparam int FW = N * 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [FW-1:0] delay_flat;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic          busy;

  int total = 0;
  int bad   = 0;

  timer_delay_arbiter_if tif ();

  timer_delay_arbiter #(.NUM_REQ(N), .DLY_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .delay_flat (delay_flat),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .tmr        (tif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] dly;
    int          irq_wait;
    logic [15:0] pl;
    logic [15:0] ph;
    bit          zero;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [N-1:0] onehot(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_wr(input string name, input logic [2:0] a, input logic [15:0] d);
    check(name, {11'd0, tif.tmr_chipselect, tif.tmr_write_n, tif.tmr_address, tif.tmr_writedata},
          {11'd0, 1'b1, 1'b0, a, d});
  endtask

  task automatic chk_nowr(input string name);
    check(name, {30'd0, tif.tmr_chipselect, tif.tmr_write_n}, 32'd1);
  endtask

  // From the cycle req is presented up to the first WAIT_IRQ cycle.
  task automatic start_to_wait(input string tag, input logic [N-1:0] g,
                               input logic [15:0] pl, input logic [15:0] ph);
    @(negedge clk);
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " busy"}, 32'(busy), 32'd1);
    chk_wr({tag, " period_l"}, 3'd2, pl);
    delay_flat = ~delay_flat;
    @(negedge clk);
    chk_wr({tag, " period_h"}, 3'd3, ph);
    @(negedge clk);
    chk_wr({tag, " control"}, 3'd1, 16'h0005);
    @(negedge clk);
    chk_nowr({tag, " wait bus"});
    check({tag, " wait grant"}, 32'(grant), 32'(g));
  endtask

  // From a WAIT_IRQ cycle: raise irq, expect status clear, done, then idle.
  task automatic irq_to_done(input string tag, input logic [N-1:0] g, input bit drop);
    tif.tmr_irq = 1'b1;
    @(negedge clk);
    chk_wr({tag, " clear"}, 3'd0, 16'h0000);
    check({tag, " no early done"}, 32'(done), 32'd0);
    tif.tmr_irq = 1'b0;
    @(negedge clk);
    check({tag, " done"}, 32'(done), 32'(g));
    check({tag, " grant at done"}, 32'(grant), 32'(g));
    chk_nowr({tag, " done bus"});
    if (drop) req = req & ~g;
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " idle grant"}, 32'(grant), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{idx: 1, dly: 32'd100,        irq_wait: 3, pl: 16'h0064, ph: 16'h0000, zero: 1'b0};
    vecs[1] = '{idx: 3, dly: 32'h0001_86A0,  irq_wait: 1, pl: 16'h86A0, ph: 16'h0001, zero: 1'b0};
    vecs[2] = '{idx: 0, dly: 32'hFFFF_FFFF,  irq_wait: 0, pl: 16'hFFFF, ph: 16'hFFFF, zero: 1'b0};
    vecs[3] = '{idx: 2, dly: 32'd0,          irq_wait: 0, pl: 16'h0000, ph: 16'h0000, zero: 1'b1};
    vecs[4] = '{idx: 2, dly: 32'h0001_0000,  irq_wait: 2, pl: 16'h0000, ph: 16'h0001, zero: 1'b0};

    reset_n     = 1'b0;
    req         = '0;
    delay_flat  = '0;
    tif.tmr_irq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset grant", 32'(grant), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset bus", {11'd0, tif.tmr_chipselect, tif.tmr_write_n, tif.tmr_address, tif.tmr_writedata},
          {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
    reset_n = 1'b1;

    // Single-requester vectors.
    for (int i = 0; i < 5; i++) begin
      string tag;
      logic [N-1:0] g;
      tag        = $sformatf("v%0d", i);
      g          = onehot(vecs[i].idx);
      req        = g;
      delay_flat = FW'(vecs[i].dly) << (32 * vecs[i].idx);
      if (vecs[i].zero) begin
        @(negedge clk);
        check({tag, " grant"}, 32'(grant), 32'(g));
        check({tag, " done"}, 32'(done), 32'(g));
        chk_nowr({tag, " zero bus"});
        req = '0;
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " idle grant"}, 32'(grant), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        chk_nowr({tag, " idle bus"});
      end else begin
        start_to_wait(tag, g, vecs[i].pl, vecs[i].ph);
        for (int w = 0; w < vecs[i].irq_wait; w++) begin
          @(negedge clk);
          chk_nowr({tag, " waiting bus"});
          check({tag, " waiting done"}, 32'(done), 32'd0);
        end
        irq_to_done(tag, g, 1'b1);
      end
    end

    // Round robin with all four requesting from a fresh pointer.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    req        = 4'b1111;
    delay_flat = {4{32'd10}};
    for (int r = 0; r < 5; r++) begin
      string tag;
      tag = $sformatf("rr%0d", r);
      start_to_wait(tag, onehot(r % 4), 16'h000A, 16'h0000);
      irq_to_done(tag, onehot(r % 4), 1'b0);
      delay_flat = {4{32'd10}};
    end
    req = '0;

    // Cancel while waiting for the irq: stop, clear, no done.
    @(negedge clk);
    req        = 4'b0001;
    delay_flat = FW'(32'd50);
    start_to_wait("cw", 4'b0001, 16'h0032, 16'h0000);
    req = '0;
    @(negedge clk);
    chk_wr("cw stop", 3'd1, 16'h0008);
    check("cw stop done", 32'(done), 32'd0);
    @(negedge clk);
    chk_wr("cw clear", 3'd0, 16'h0000);
    check("cw clear done", 32'(done), 32'd0);
    @(negedge clk);
    check("cw idle grant", 32'(grant), 32'd0);
    check("cw idle busy", 32'(busy), 32'd0);
    check("cw idle done", 32'(done), 32'd0);
    chk_nowr("cw idle bus");

    // Cancel and irq in the same cycle: irq wins, no stop write.
    req        = 4'b0001;
    delay_flat = FW'(32'd7);
    start_to_wait("ci", 4'b0001, 16'h0007, 16'h0000);
    req = '0;
    irq_to_done("ci", 4'b0001, 1'b0);

    // Cancel during the period writes with a stale irq that must be ignored.
    req         = 4'b0001;
    delay_flat  = FW'(32'd9);
    tif.tmr_irq = 1'b1;
    @(negedge clk);
    check("cp grant", 32'(grant), 32'd1);
    chk_wr("cp period_l", 3'd2, 16'h0009);
    req = '0;
    @(negedge clk);
    chk_wr("cp period_h", 3'd3, 16'h0000);
    @(negedge clk);
    chk_wr("cp control", 3'd1, 16'h0005);
    tif.tmr_irq = 1'b0;
    @(negedge clk);
    chk_nowr("cp wait bus");
    check("cp wait done", 32'(done), 32'd0);
    @(negedge clk);
    chk_wr("cp stop", 3'd1, 16'h0008);
    @(negedge clk);
    chk_wr("cp clear", 3'd0, 16'h0000);
    @(negedge clk);
    check("cp idle grant", 32'(grant), 32'd0);
    check("cp idle busy", 32'(busy), 32'd0);
    check("cp idle done", 32'(done), 32'd0);

    // Reset in WAIT_IRQ after owner 2 moved the pointer to 3.
    req        = 4'b0100;
    delay_flat = FW'(32'd20) << 64;
    start_to_wait("rs", 4'b0100, 16'h0014, 16'h0000);
    reset_n = 1'b0;
    @(negedge clk);
    check("rs grant", 32'(grant), 32'd0);
    check("rs done", 32'(done), 32'd0);
    check("rs busy", 32'(busy), 32'd0);
    check("rs bus", {11'd0, tif.tmr_chipselect, tif.tmr_write_n, tif.tmr_address, tif.tmr_writedata},
          {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
    reset_n    = 1'b1;
    req        = 4'b1001;
    delay_flat = {32'd5, 32'd0, 32'd0, 32'd6};
    start_to_wait("rs2", 4'b0001, 16'h0006, 16'h0000);
    irq_to_done("rs2", 4'b0001, 1'b1);
    req = '0;
    @(negedge clk);
    check("end busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
